carry_save_resolver: RTL and testbench
======================================

Name: carry_save_resolver

Overview:
- Converts a carry-save pair (sum vector s, carry vector cout), as produced by the carry_save_adder, back to a single binary value.
- Performs the carry-propagate addition s + (cout << 1) sequentially, CHUNK bits per cycle, using a registered inter-chunk carry.
- Sits downstream of carry-save reduction stages (MAC/accumulator datapaths), where a full-width ripple adder would limit clock rate.
- Uses valid/ready handshakes on both input and output.

Parameters:
- WIDTH, 8, width of each carry-save input vector.
- CHUNK, 4, bits resolved per BUSY cycle, 1 <= CHUNK <= WIDTH+2.
- NCHUNK, derived ceil((WIDTH+2)/CHUNK), number of BUSY cycles. Not user-overridable; 3 at default.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  s_in/c_in are valid.
- in_ready  output  1  block can accept a pair.
- s_in  input  WIDTH  carry-save sum vector.
- c_in  input  WIDTH  carry-save carry vector (weight 2, i.e. shifted left one before adding).
- out_valid  output  1  result holds the resolved value.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH+2  binary value s_in + 2*c_in.
- busy  output  1  high in BUSY state.

Behaviour:
- Reset (clk edge with rst=1): state IDLE, chunk index 0, carry register 0, result 0, out_valid 0, busy 0, in_ready 1 on the following cycle. rst has priority over all other inputs.
- Operand extension on accept: S = {2'b0, s_in}; C = {1'b0, c_in, 1'b0}. Both are WIDTH+2 bits and are latched into internal registers.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - in_valid=1 at an edge: latch S and C, clear carry and index, go to BUSY.
- BUSY:
  - in_ready=0, busy=1.
  - Each edge adds chunk bits [i*CHUNK +: CHUNK] of S and C plus the carry register.
  - Writes the CHUNK-bit sum into the same slice of result and stores the carry-out; index increments.
  - Final chunk may be narrower than CHUNK (2 bits at default). Only its valid bits are written.
  - After chunk NCHUNK-1 is processed, go to DONE.
  - Final carry-out is always 0, since the value fits in WIDTH+2 bits. No overflow output exists.
- DONE:
  - out_valid=1; result stable.
  - in_ready=0; in_valid ignored.
  - out_ready=1 at an edge: go to IDLE with out_valid=0 on the next cycle. Otherwise hold indefinitely.
- Latency: out_valid rises exactly NCHUNK edges after the accepting edge (3 at default). Initiation interval = NCHUNK+2 cycles with out_ready held high.
- s_in/c_in changes after acceptance have no effect.
- result keeps its last value in IDLE. Only the DONE-qualified value is meaningful.
- Reset in BUSY or DONE: operation is discarded and the block returns to IDLE; no out_valid pulse.
- CHUNK = WIDTH+2: NCHUNK=1, single BUSY cycle.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
- Reset then s_in=44, c_in=1 (the pair for 12+33+1) -> in_ready drops the next cycle, busy high 3 cycles, out_valid high on the 3rd edge after accept, result=46.
- s_in=22, c_in=1, then s_in=6, c_in=1 back-to-back with out_ready=1 -> results 24 then 8. Second accept occurs only once IDLE is re-entered; in_ready=0 throughout BUSY/DONE.
- All-ones s_in=255, c_in=255 -> result=765 (0x2FD). Exercises carry across every chunk boundary and the top 2-bit chunk.
- out_ready=0 for 10 cycles in DONE with s_in=15, c_in=1 -> out_valid and result=17 held stable. in_valid pulses during the stall are ignored; release gives exactly one transfer.
- rst asserted in the 2nd BUSY cycle of s_in=200, c_in=50 -> next cycle IDLE, out_valid=0, in_ready=1. A subsequent s_in=0, c_in=0 gives result=0.
- Re-run with CHUNK=1 (10 BUSY cycles) and CHUNK=10 (1 BUSY cycle) on s_in=170, c_in=85 -> result=340 in both, with latency equal to NCHUNK.

Source files
------------

// File: rtl/carry_save_resolver.sv
// ---------------------------------------------------------------------------
// carry_save_resolver
//   Resolves a carry-save pair (s, c) into a binary value s + 2*c. The
//   carry-propagate add runs sequentially, CHUNK bits per cycle, with a
//   registered inter-chunk carry. This keeps the ripple path short enough to
//   sit behind carry-save reduction stages.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (priority over everything)
//   in_valid   s_in/c_in valid          in_ready   pair can be accepted (IDLE)
//   s_in       sum vector [WIDTH]       c_in       carry vector [WIDTH], weight 2
//   out_valid  result valid (DONE)      out_ready  consumer takes result
//   result     s_in + 2*c_in [WIDTH+2]  busy       resolving chunks (BUSY)
// ---------------------------------------------------------------------------
module carry_save_resolver #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] s_in,
  input  logic [WIDTH-1:0] c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] result,
  output logic             busy
);

  localparam int W2     = WIDTH + 2;
  localparam int NCHUNK = (W2 + CHUNK - 1) / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            cy_q, cy_d;
  logic [W2-1:0]   s_q, s_d;
  logic [W2-1:0]   c_q, c_d;
  logic [W2-1:0]   res_q, res_d;

  logic            last_chunk;
  int              shamt;
  logic [W2-1:0]   s_sh, c_sh;
  logic [CHUNK:0]  csum;
  logic [W2-1:0]   sum_w, mask_w;

  assign last_chunk = (idx_q == IW'(NCHUNK - 1));

  // ---- chunk adder --------------------------------------------------------
  // Shifting the operands down zero-fills above W2, so a narrow final chunk
  // naturally sees zeros in its missing upper bits. Shifting the sum and mask
  // back up drops anything beyond W2, so only valid result bits are written.
  always_comb begin
    shamt  = int'(idx_q) * CHUNK;
    s_sh   = s_q >> shamt;
    c_sh   = c_q >> shamt;
    csum   = {1'b0, s_sh[CHUNK-1:0]} + {1'b0, c_sh[CHUNK-1:0]}
           + (CHUNK+1)'(cy_q);
    sum_w  = W2'(csum[CHUNK-1:0]) << shamt;
    mask_w = W2'({CHUNK{1'b1}}) << shamt;
  end

  // ---- FSM: state register ------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---- FSM: next state ----------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = BUSY;
      BUSY:    if (last_chunk) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // ---- FSM: outputs (pure state decode, no input-to-output paths) ---------
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q == BUSY);
    out_valid = (state_q == DONE);
  end

  // ---- datapath next state ------------------------------------------------
  always_comb begin
    idx_d = idx_q;
    cy_d  = cy_q;
    s_d   = s_q;
    c_d   = c_q;
    res_d = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Carry vector carries weight 2: shift it up one on capture.
          s_d   = {2'b00, s_in};
          c_d   = {1'b0, c_in, 1'b0};
          idx_d = '0;
          cy_d  = 1'b0;
        end
      end
      BUSY: begin
        res_d = (res_q & ~mask_w) | sum_w;
        cy_d  = csum[CHUNK];
        idx_d = last_chunk ? '0 : idx_q + 1'b1;
      end
      default: ;
    endcase
  end

  // ---- datapath registers -------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      cy_q  <= 1'b0;
      s_q   <= '0;
      c_q   <= '0;
      res_q <= '0;
    end else begin
      idx_q <= idx_d;
      cy_q  <= cy_d;
      s_q   <= s_d;
      c_q   <= c_d;
      res_q <= res_d;
    end
  end

  assign result = res_q;

endmodule

// File: tb/tb_carry_save_resolver.sv
// ---------------------------------------------------------------------------
// tb_carry_save_resolver
//   Three instances (CHUNK = 4, 1, 10 at WIDTH = 8) are driven through
//   handshaked transfers. Expected results are s + 2*c in plain integer
//   arithmetic, and the expected latency is ceil((WIDTH+2)/CHUNK).
// ---------------------------------------------------------------------------
module tb_carry_save_resolver;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid  [3];
  logic           in_ready  [3];
  logic [W-1:0]   s_in      [3];
  logic [W-1:0]   c_in      [3];
  logic           out_valid [3];
  logic           out_ready [3];
  logic [W+1:0]   result    [3];
  logic           busy      [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  carry_save_resolver #(.WIDTH(W), .CHUNK(4)) u_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .s_in(s_in[0]), .c_in(c_in[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .result(result[0]), .busy(busy[0]));

  carry_save_resolver #(.WIDTH(W), .CHUNK(1)) u_c1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .s_in(s_in[1]), .c_in(c_in[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .result(result[1]), .busy(busy[1]));

  carry_save_resolver #(.WIDTH(W), .CHUNK(10)) u_c10 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .s_in(s_in[2]), .c_in(c_in[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .result(result[2]), .busy(busy[2]));

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int nch(input int k);
    int ch;
    ch = (k == 0) ? 4 : (k == 1) ? 1 : 10;
    return (W + 2 + ch - 1) / ch;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transfer on instance k; stall = cycles out_ready is held low in DONE.
  task automatic xfer(input int k, input int s, input int c, input int stall);
    int exp, n, nb;
    exp = s + 2 * c;
    chk("idle_in_ready", int'(in_ready[k]), 1);
    out_ready[k] = (stall == 0);
    in_valid[k]  = 1'b1;
    s_in[k]      = W'(s);
    c_in[k]      = W'(c);
    tick();
    // Inputs after acceptance must not matter.
    in_valid[k] = 1'b0;
    s_in[k]     = W'($urandom);
    c_in[k]     = W'($urandom);
    n  = 0;
    nb = 0;
    while (!out_valid[k] && n < 64) begin
      chk("busy_in_ready", int'(in_ready[k]), 0);
      nb += int'(busy[k]);
      tick();
      n++;
    end
    chk("latency", n, nch(k));
    chk("busy_cycles", nb, nch(k));
    chk("result", int'(result[k]), exp);
    for (int i = 0; i < stall; i++) begin
      chk("stall_out_valid", int'(out_valid[k]), 1);
      chk("stall_result", int'(result[k]), exp);
      chk("stall_in_ready", int'(in_ready[k]), 0);
      in_valid[k] = 1'($urandom_range(0, 1));
      s_in[k]     = W'($urandom);
      c_in[k]     = W'($urandom);
      tick();
    end
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    tick();
    chk("post_out_valid", int'(out_valid[k]), 0);
    chk("post_in_ready", int'(in_ready[k]), 1);
    chk("post_result_hold", int'(result[k]), exp);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = 1'b0;
      s_in[k]      = '0;
      c_in[k]      = '0;
      out_ready[k] = 1'b0;
    end
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rst_out_valid", int'(out_valid[k]), 0);
      chk("rst_in_ready", int'(in_ready[k]), 1);
      chk("rst_busy", int'(busy[k]), 0);
      chk("rst_result", int'(result[k]), 0);
    end

    // Directed cases on the default CHUNK=4 instance.
    xfer(0, 44, 1, 0);
    xfer(0, 22, 1, 0);
    xfer(0, 6, 1, 0);
    xfer(0, 255, 255, 0);
    xfer(0, 15, 1, 10);

    // Reset in the second BUSY cycle discards the operation.
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    s_in[0]      = 8'd200;
    c_in[0]      = 8'd50;
    tick();
    in_valid[0] = 1'b0;
    tick();
    chk("mid_busy", int'(busy[0]), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_out_valid", int'(out_valid[0]), 0);
    chk("abort_in_ready", int'(in_ready[0]), 1);
    chk("abort_busy", int'(busy[0]), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_pulse", int'(out_valid[0]), 0);
    end
    xfer(0, 0, 0, 0);

    // Narrowest and widest chunking.
    xfer(1, 170, 85, 0);
    xfer(2, 170, 85, 0);
    xfer(1, 255, 255, 2);
    xfer(2, 255, 255, 2);

    // Randomized traffic across all instances.
    for (int i = 0; i < 40; i++)
      xfer(int'($urandom_range(0, 2)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
